// File: rtl/riscv_uart_tx.sv
// 8N1 UART transmitter with a synchronous byte FIFO in front of it.
// The FIFO absorbs bursts from the core; the FSM drains it one frame at a time.
module riscv_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic       i_riscv_uart_tx_clk,
  input  logic       i_riscv_uart_tx_rst,
  input  logic [7:0] i_riscv_uart_tx_data,
  input  logic       i_riscv_uart_tx_valid,
  output logic       o_riscv_uart_tx_fifo_full,
  output logic       o_riscv_uart_tx_fifo_empty,
  output logic       o_riscv_uart_tx_busy,
  output logic       o_riscv_uart_tx_serial
);

  // state | meaning
  // IDLE  | line high; pops the FIFO head when one is available
  // START | start bit (low) for one bit period
  // DATA  | eight data bits, LSB first, from the shift register
  // STOP  | stop bit (high) for one bit period
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              serial_q, serial_d;
  logic              baud_last;

  assign o_riscv_uart_tx_fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign o_riscv_uart_tx_fifo_empty = (count == '0);
  assign o_riscv_uart_tx_busy       = (state_q != IDLE) || !o_riscv_uart_tx_fifo_empty;
  assign o_riscv_uart_tx_serial     = serial_q;

  // Push uses the registered full flag, so a push in the same cycle as a pop
  // from a full FIFO is still dropped.
  assign push = i_riscv_uart_tx_valid && !o_riscv_uart_tx_fifo_full;

  always_ff @(posedge i_riscv_uart_tx_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_riscv_uart_tx_data;
    end
  end

  always_ff @(posedge i_riscv_uart_tx_clk) begin
    if (i_riscv_uart_tx_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_riscv_uart_tx_clk) begin
    if (i_riscv_uart_tx_rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    serial_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (!o_riscv_uart_tx_fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the state being entered so it lines up with state_q.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Directed bench for riscv_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Cycle numbers are tracked in cyc; outputs are sampled 1 time unit after each edge.
module tb_riscv_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       fifo_full, fifo_empty, busy, serial;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int base;

  riscv_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_riscv_uart_tx_clk       (clk),
    .i_riscv_uart_tx_rst       (rst),
    .i_riscv_uart_tx_data      (data),
    .i_riscv_uart_tx_valid     (valid),
    .o_riscv_uart_tx_fifo_full (fifo_full),
    .o_riscv_uart_tx_fifo_empty(fifo_empty),
    .o_riscv_uart_tx_busy      (busy),
    .o_riscv_uart_tx_serial    (serial)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Checks ncyc cycles of a frame starting at cycle start; busy must stay high.
  task automatic check_frame(input logic [7:0] b, input int start, input int ncyc);
    logic exp_bit;
    int   k;
    while (cyc < start) step();
    while (cyc < start + ncyc) begin
      k = (cyc - start) / CPB;
      if (k == 0)      exp_bit = 1'b0;
      else if (k <= 8) exp_bit = b[k-1];
      else             exp_bit = 1'b1;
      chk($sformatf("frame_%h_bit%0d", b, k), serial, exp_bit);
      chk("frame_busy", busy, 1'b1);
      step();
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;

    // 1: reset then idle
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("idle_serial", serial, 1'b1);
      chk("idle_full", fifo_full, 1'b0);
      chk("idle_empty", fifo_empty, 1'b1);
      chk("idle_busy", busy, 1'b0);
      step();
    end

    // 2: single byte 0xA5
    base = cyc;
    push_byte(8'hA5);
    chk("a5_empty_n1", fifo_empty, 1'b0);
    chk("a5_serial_n1", serial, 1'b1);
    chk("a5_busy_n1", busy, 1'b1);
    check_frame(8'hA5, base + 2, 10 * CPB);
    chk("a5_busy_n42", busy, 1'b0);
    chk("a5_empty_n42", fifo_empty, 1'b1);
    chk("a5_serial_n42", serial, 1'b1);
    step();

    // 3: burst of six bytes into a four-deep FIFO; 0x06 is dropped
    base = cyc;
    for (int k = 0; k < 6; k++) begin
      data  = 8'(k + 1);
      valid = 1'b1;
      step();
      chk("burst_full", fifo_full, (cyc >= base + 5) ? 8'd1 : 8'd0);
    end
    valid = 1'b0;
    check_frame(8'h01, base + 2, 10 * CPB);
    chk("burst_gap_serial", serial, 1'b1);
    chk("burst_full_at_pop", fifo_full, 1'b1);
    step();
    chk("burst_full_after_pop", fifo_full, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_frame(8'(k + 2), base + 43 + 41 * k, 10 * CPB);
    end
    chk("burst_end_empty", fifo_empty, 1'b1);
    chk("burst_end_busy", busy, 1'b0);
    step();

    // 4: push while full in the pop cycle is dropped; retry next cycle lands
    base = cyc;
    for (int k = 0; k < 5; k++) push_byte(8'h11 + 8'(k));
    chk("full_after_fill", fifo_full, 1'b1);
    check_frame(8'h11, base + 2, 10 * CPB);
    chk("race_full_pre", fifo_full, 1'b1);
    data  = 8'h77;
    valid = 1'b1;
    step();
    chk("race_dropped_full", fifo_full, 1'b0);
    chk("race_start_bit", serial, 1'b0);
    step();
    valid = 1'b0;
    chk("retry_full", fifo_full, 1'b1);
    check_frame(8'h12, base + 43, 10 * CPB);
    check_frame(8'h13, base + 84, 10 * CPB);
    check_frame(8'h14, base + 125, 10 * CPB);
    check_frame(8'h15, base + 166, 10 * CPB);
    check_frame(8'h77, base + 207, 10 * CPB);
    chk("race_end_busy", busy, 1'b0);
    step();

    // 5: reset mid-frame aborts and flushes the FIFO
    base = cyc;
    push_byte(8'h3C);
    push_byte(8'hEE);
    check_frame(8'h3C, base + 2, 18);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_serial", serial, 1'b1);
    chk("abort_empty", fifo_empty, 1'b1);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 50; i++) begin
      chk("abort_quiet_serial", serial, 1'b1);
      chk("abort_quiet_busy", busy, 1'b0);
      step();
    end
    base = cyc;
    push_byte(8'h81);
    check_frame(8'h81, base + 2, 10 * CPB);
    chk("post_abort_busy", busy, 1'b0);
    step();

    // 6: 0xFF then 0x00 back to back, one high gap cycle with busy held
    base = cyc;
    push_byte(8'hFF);
    push_byte(8'h00);
    check_frame(8'hFF, base + 2, 10 * CPB);
    chk("gap_serial", serial, 1'b1);
    chk("gap_busy", busy, 1'b1);
    step();
    check_frame(8'h00, base + 43, 10 * CPB);
    chk("b2b_end_busy", busy, 1'b0);
    chk("b2b_end_serial", serial, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
